// File: rtl/l1_mem_arbiter_if.sv
// Bus bundle joining the split L1 caches and the cacheline adaptor through the arbiter.
// The arbiter takes the slave view; the cache/adaptor side takes the master view.
interface l1_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) ();

  // I-cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  // D-cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  // Cacheline adaptor side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/l1_mem_arbiter.sv
// Shares one cacheline adaptor between the L1 I-cache and D-cache, one line
// transaction at a time, returning the adaptor response only to the winner.
module l1_mem_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned LINE_W          = 256,
  parameter bit          DCACHE_PRIORITY = 1'b1
) (
  input logic             clk,
  input logic             rst,
  l1_mem_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((LINE_W / 8) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;

  logic i_req;
  logic d_req;
  logic pick_d;
  logic mem_read;
  logic mem_write;
  logic i_resp;
  logic d_resp;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // On a tie, either D always wins or the grant alternates away from the last winner.
  assign pick_d = (i_req && d_req) ? (DCACHE_PRIORITY || (last_grant_q == GNT_I))
                                   : d_req;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (pick_d) begin
            state_d      = SERVE_D;
            last_grant_d = GNT_D;
            addr_d       = bus.d_address & ~OFFSET_MASK;
            write_d      = bus.d_write;
            wdata_d      = bus.d_wdata;
          end else begin
            state_d      = SERVE_I;
            last_grant_d = GNT_I;
            addr_d       = bus.i_address & ~OFFSET_MASK;
            write_d      = 1'b0;
          end
        end
      end

      SERVE_I: begin
        mem_read  = !write_q;
        mem_write = write_q;
        if (bus.mem_resp) begin
          i_resp  = 1'b1;
          state_d = RELEASE;
        end
      end

      SERVE_D: begin
        mem_read  = !write_q;
        mem_write = write_q;
        if (bus.mem_resp) begin
          d_resp  = 1'b1;
          state_d = RELEASE;
        end
      end

      // One quiet cycle lets the winner drop its request before the next arbitration.
      RELEASE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_resp      = i_resp;
  assign bus.d_resp      = d_resp;
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;

  // Simulation-only protocol checks.
  d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(bus.d_read && bus.d_write))
    else $error("d_read and d_write asserted together; write takes precedence");

  mem_op_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write))
    else $error("mem_read and mem_write asserted together");

  resp_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(i_resp && d_resp))
    else $error("i_resp and d_resp asserted together");

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed bench for l1_mem_arbiter: a D-priority instance and a round-robin
// instance, with a scoreboard of expected adaptor transactions.
module tb_l1_mem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 256;
  localparam int          TIMEOUT = 20;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct {
    bit    sel;
    bit    is_d;
    bit    write;
    addr_t addr;
    line_t wdata;
  } exp_t;

  logic  clk;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];

  logic  s_rd, s_wr, s_iresp, s_dresp;
  addr_t s_addr;
  line_t s_wdata, s_irdata, s_drdata;

  l1_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus_p1 ();
  l1_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus_rr ();

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DCACHE_PRIORITY(1'b1)) u_dut_p1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_p1)
  );

  l1_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .DCACHE_PRIORITY(1'b0)) u_dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input line_t obs, input line_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit sel);
    if (sel) begin
      s_rd = bus_rr.mem_read;  s_wr = bus_rr.mem_write;
      s_addr = bus_rr.mem_address; s_wdata = bus_rr.mem_wdata;
      s_iresp = bus_rr.i_resp; s_dresp = bus_rr.d_resp;
      s_irdata = bus_rr.i_rdata; s_drdata = bus_rr.d_rdata;
    end else begin
      s_rd = bus_p1.mem_read;  s_wr = bus_p1.mem_write;
      s_addr = bus_p1.mem_address; s_wdata = bus_p1.mem_wdata;
      s_iresp = bus_p1.i_resp; s_dresp = bus_p1.d_resp;
      s_irdata = bus_p1.i_rdata; s_drdata = bus_p1.d_rdata;
    end
  endtask

  task automatic set_i(input bit sel, input logic rd, input addr_t addr);
    if (sel) begin bus_rr.i_read = rd; bus_rr.i_address = addr; end
    else     begin bus_p1.i_read = rd; bus_p1.i_address = addr; end
  endtask

  task automatic set_d(input bit sel, input logic rd, input logic wr, input addr_t addr,
                       input line_t wdata);
    if (sel) begin
      bus_rr.d_read = rd; bus_rr.d_write = wr; bus_rr.d_address = addr; bus_rr.d_wdata = wdata;
    end else begin
      bus_p1.d_read = rd; bus_p1.d_write = wr; bus_p1.d_address = addr; bus_p1.d_wdata = wdata;
    end
  endtask

  task automatic set_d_addr(input bit sel, input addr_t addr);
    if (sel) bus_rr.d_address = addr;
    else     bus_p1.d_address = addr;
  endtask

  task automatic set_mem(input bit sel, input logic resp, input line_t rdata);
    if (sel) begin bus_rr.mem_resp = resp; bus_rr.mem_rdata = rdata; end
    else     begin bus_p1.mem_resp = resp; bus_p1.mem_rdata = rdata; end
  endtask

  task automatic drop_req(input bit sel, input bit is_d);
    if (sel) begin
      if (is_d) begin bus_rr.d_read = 1'b0; bus_rr.d_write = 1'b0; end
      else bus_rr.i_read = 1'b0;
    end else begin
      if (is_d) begin bus_p1.d_read = 1'b0; bus_p1.d_write = 1'b0; end
      else bus_p1.i_read = 1'b0;
    end
  endtask

  task automatic expect_txn(input bit sel, input bit is_d, input bit write, input addr_t addr,
                            input line_t wdata);
    exp_t e;
    e.sel = sel; e.is_d = is_d; e.write = write; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  // Waits for the next adaptor request, compares it with the scoreboard head,
  // stalls `delay` cycles, answers with rdata and checks the response routing.
  task automatic serve(input bit sel, input int delay, input line_t rdata, input bit drop,
                       input bit chg_addr, input bit spur, output int lat);
    exp_t e;
    bit   got;
    lat = 0;
    got = 1'b0;
    while (!got && lat < TIMEOUT) begin
      @(negedge clk);
      sample(sel);
      if (s_rd || s_wr) got = 1'b1;
      else lat++;
    end
    check("grant_seen", line_t'(got), line_t'(1));
    if (!got) return;
    if (sb.size() == 0) begin
      check("scoreboard_has_entry", line_t'(sb.size()), line_t'(1));
      return;
    end
    e = sb.pop_front();
    check("mem_write", line_t'(s_wr), line_t'(e.write));
    check("mem_read", line_t'(s_rd), line_t'(!e.write));
    check("mem_address", line_t'(s_addr), line_t'(e.addr));
    if (e.write) check("mem_wdata", s_wdata, e.wdata);

    for (int k = 0; k < delay; k++) begin
      @(posedge clk); #1;
      if (chg_addr && k == 0) set_d_addr(sel, 32'h0000_3000);
      sample(sel);
      check("addr_stable", line_t'(s_addr), line_t'(e.addr));
      check("req_held", line_t'({s_rd, s_wr}), line_t'({!e.write, e.write}));
      check("no_early_resp", line_t'({s_iresp, s_dresp}), '0);
    end

    set_mem(sel, 1'b1, rdata);
    @(negedge clk);
    sample(sel);
    check("own_resp", line_t'(e.is_d ? s_dresp : s_iresp), line_t'(1));
    check("other_resp", line_t'(e.is_d ? s_iresp : s_dresp), '0);
    check("rdata", e.is_d ? s_drdata : s_irdata, rdata);

    @(posedge clk); #1;
    set_mem(sel, spur, rdata);
    if (drop) drop_req(sel, e.is_d);
    @(negedge clk);
    sample(sel);
    check("release_no_req", line_t'({s_rd, s_wr}), '0);
    check("release_no_resp", line_t'({s_iresp, s_dresp}), '0);
    if (spur) begin
      @(posedge clk); #1;
      set_mem(sel, 1'b0, '0);
    end
  endtask

  initial begin
    int    lat;
    bit    got;
    line_t pat_a5;
    line_t pat_w;
    line_t pat_w2;

    pat_a5 = {32{8'hA5}};
    pat_w  = {8{32'hDEAD_BEEF}};
    pat_w2 = {8{32'h0BAD_F00D}};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      set_i(s[0], 1'b0, '0);
      set_d(s[0], 1'b0, 1'b0, '0, '0);
      set_mem(s[0], 1'b0, '0);
    end

    // Reset state
    @(posedge clk); #1;
    sample(1'b0);
    check("rst_mem_req", line_t'({s_rd, s_wr}), '0);
    check("rst_mem_address", line_t'(s_addr), '0);
    check("rst_mem_wdata", s_wdata, '0);
    check("rst_resp", line_t'({s_iresp, s_dresp}), '0);
    sample(1'b1);
    check("rst_rr_mem_req", line_t'({s_rd, s_wr}), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Lone I-cache read; address aligned, grant one cycle after the request
    set_i(1'b0, 1'b1, 32'h0000_1064);
    expect_txn(1'b0, 1'b0, 1'b0, 32'h0000_1060, '0);
    serve(1'b0, 4, pat_a5, 1'b1, 1'b0, 1'b0, lat);
    check("lone_i_latency", line_t'(lat), line_t'(1));

    // Simultaneous I read and D write with D priority: D first, then I
    @(posedge clk); #1;
    set_i(1'b0, 1'b1, 32'h0000_40A0);
    set_d(1'b0, 1'b0, 1'b1, 32'h0000_51FF, pat_w);
    expect_txn(1'b0, 1'b1, 1'b1, 32'h0000_51E0, pat_w);
    expect_txn(1'b0, 1'b0, 1'b0, 32'h0000_40A0, '0);
    serve(1'b0, 2, {8{32'h1111_2222}}, 1'b1, 1'b0, 1'b0, lat);
    serve(1'b0, 3, {8{32'h3333_4444}}, 1'b1, 1'b0, 1'b0, lat);
    check("next_grant_after_release", line_t'(lat), line_t'(1));

    // Round-robin instance, both requesting continuously: D, I, D, I
    @(posedge clk); #1;
    set_i(1'b1, 1'b1, 32'h0000_4000);
    set_d(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0);
    expect_txn(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0);
    expect_txn(1'b1, 1'b0, 1'b0, 32'h0000_4000, '0);
    expect_txn(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0);
    expect_txn(1'b1, 1'b0, 1'b0, 32'h0000_4000, '0);
    serve(1'b1, 1, {8{32'hAAAA_0001}}, 1'b0, 1'b0, 1'b0, lat);
    serve(1'b1, 2, {8{32'hAAAA_0002}}, 1'b0, 1'b0, 1'b0, lat);
    serve(1'b1, 1, {8{32'hAAAA_0003}}, 1'b0, 1'b0, 1'b0, lat);
    serve(1'b1, 2, {8{32'hAAAA_0004}}, 1'b0, 1'b0, 1'b0, lat);
    @(posedge clk); #1;
    set_i(1'b1, 1'b0, '0);
    set_d(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    sample(1'b1);
    check("rr_idle_after_drop", line_t'({s_rd, s_wr}), '0);

    // D address changes mid-service; adaptor address must hold
    @(posedge clk); #1;
    set_d(1'b0, 1'b1, 1'b0, 32'h0000_2000, '0);
    expect_txn(1'b0, 1'b1, 1'b0, 32'h0000_2000, '0);
    serve(1'b0, 3, {8{32'h5A5A_5A5A}}, 1'b1, 1'b1, 1'b0, lat);

    // Asynchronous reset during a D writeback
    @(posedge clk); #1;
    set_d(1'b0, 1'b0, 1'b1, 32'h0000_6000, pat_w2);
    got = 1'b0;
    for (int k = 0; k < TIMEOUT && !got; k++) begin
      @(negedge clk);
      sample(1'b0);
      got = s_wr;
    end
    check("rst_test_write_granted", line_t'(got), line_t'(1));
    @(posedge clk); #1;
    sample(1'b0);
    check("write_held_before_rst", line_t'(s_wr), line_t'(1));
    rst = 1'b1;
    #1;
    sample(1'b0);
    check("rst_drops_write", line_t'({s_rd, s_wr}), '0);
    check("rst_no_d_resp", line_t'({s_iresp, s_dresp}), '0);
    check("rst_clears_address", line_t'(s_addr), '0);
    check("rst_clears_wdata", s_wdata, '0);
    set_d(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    sample(1'b0);
    check("rst_held_quiet", line_t'({s_rd, s_wr, s_iresp, s_dresp}), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_i(1'b0, 1'b1, 32'h0000_7010);
    expect_txn(1'b0, 1'b0, 1'b0, 32'h0000_7000, '0);
    serve(1'b0, 2, {8{32'hC0DE_0001}}, 1'b1, 1'b0, 1'b0, lat);
    check("post_reset_latency", line_t'(lat), line_t'(1));

    // Spurious mem_resp while IDLE
    @(posedge clk); #1;
    set_mem(1'b0, 1'b1, pat_a5);
    #1;
    sample(1'b0);
    check("spur_idle_no_resp", line_t'({s_iresp, s_dresp}), '0);
    @(posedge clk); #1;
    set_mem(1'b0, 1'b0, '0);
    sample(1'b0);
    check("spur_idle_no_req", line_t'({s_rd, s_wr}), '0);

    // Spurious mem_resp during RELEASE, then the pending I request is served normally
    set_i(1'b0, 1'b1, 32'h0000_8000);
    set_d(1'b0, 1'b1, 1'b0, 32'h0000_9000, '0);
    expect_txn(1'b0, 1'b1, 1'b0, 32'h0000_9000, '0);
    expect_txn(1'b0, 1'b0, 1'b0, 32'h0000_8000, '0);
    serve(1'b0, 2, {8{32'hFEED_0001}}, 1'b1, 1'b0, 1'b1, lat);
    check("spur_idle_then_grant_latency", line_t'(lat), line_t'(1));
    serve(1'b0, 2, {8{32'hFEED_0002}}, 1'b1, 1'b0, 1'b0, lat);
    check("grant_after_spurious_release", line_t'(lat), line_t'(1));

    repeat (3) @(posedge clk);
    #1;
    sample(1'b0);
    check("final_idle", line_t'({s_rd, s_wr, s_iresp, s_dresp}), '0);
    check("scoreboard_drained", line_t'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
